// File: rtl/baw_pkg.sv
// Shared definitions for the Black-and-White round controller:
// FSM state encodings, comparator result codes, default game sizes
// and the one-hot card decoder.
package baw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LEAD_PICK   = 3'd1,
    ST_FOLLOW_PICK = 3'd2,
    ST_COMPARE     = 3'd3,
    ST_SCORE       = 3'd4,
    ST_DONE        = 3'd5
  } baw_state_t;

  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;

  localparam int NUM_CARDS_DEF  = 9;
  localparam int WIN_TARGET_DEF = 5;

  // Index of the set bit; only meaningful for a one-hot input.
  function automatic logic [3:0] onehot9_to_idx(input logic [8:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 9; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/baw_round_controller_if.sv
// Board/datapath bundle of the round controller. The master side is the
// board plus comparator (drives buttons, switches, cmp_result); the slave
// side is the controller itself.
interface baw_round_controller_if;
  logic       btn_start;
  logic       btn_confirm;
  logic       btn_abort;
  logic [8:0] sw_sel;
  logic [1:0] cmp_result;
  logic [3:0] p1_card;
  logic [3:0] p2_card;
  logic [8:0] p1_used;
  logic [8:0] p2_used;
  logic       cmp_req;
  logic       leader;
  logic [3:0] round;
  logic [3:0] p1_wins;
  logic [3:0] p2_wins;
  logic       game_over;
  logic [1:0] game_winner;
  logic       pick_err;
  logic [2:0] state_o;

  modport master (
    output btn_start, btn_confirm, btn_abort, sw_sel, cmp_result,
    input  p1_card, p2_card, p1_used, p2_used, cmp_req, leader, round,
           p1_wins, p2_wins, game_over, game_winner, pick_err, state_o
  );

  modport slave (
    input  btn_start, btn_confirm, btn_abort, sw_sel, cmp_result,
    output p1_card, p2_card, p1_used, p2_used, cmp_req, leader, round,
           p1_wins, p2_wins, game_over, game_winner, pick_err, state_o
  );
endinterface

// File: rtl/baw_btn_edge.sv
// Raw button conditioner: 2-flop synchronizer followed by a registered
// rising-edge detector. The 1-cycle pulse appears 3 clk cycles after the
// raw rising edge.
module baw_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1, r_sync2, r_prev, r_pulse;

  // Synchronize, remember the previous level, and register the edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/baw_round_controller.sv
// Black-and-White game sequencer: start, leader pick, follower pick,
// compare, score, next round, with legal-pick enforcement and game-over.
// Optional feature macro: BAW_TIMEOUT_EN (auto-play of the acting player's
// lowest unused card after TIMEOUT_CYCLES without an accepted pick).
module baw_round_controller
  import baw_pkg::*;
#(
  parameter int NUM_CARDS      = NUM_CARDS_DEF,
  parameter int WIN_TARGET     = WIN_TARGET_DEF,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input logic                   clk,
  input logic                   rst,
  baw_round_controller_if.slave io_bus
);

  baw_state_t r_state;
  logic [3:0] r_p1_card, r_p2_card, r_round, r_p1_wins, r_p2_wins;
  logic [8:0] r_p1_used, r_p2_used;
  logic       r_cmp_req, r_leader, r_game_over, r_pick_err;
  logic [1:0] r_game_winner, r_res;

  logic w_start, w_confirm, w_abort;

  baw_btn_edge u_start   (.clk(clk), .rst(rst), .i_btn(io_bus.btn_start),   .o_pulse(w_start));
  baw_btn_edge u_confirm (.clk(clk), .rst(rst), .i_btn(io_bus.btn_confirm), .o_pulse(w_confirm));
  baw_btn_edge u_abort   (.clk(clk), .rst(rst), .i_btn(io_bus.btn_abort),   .o_pulse(w_abort));

  logic       w_in_pick, w_actor, w_onehot, w_legal, w_tmo, w_play, w_err;
  logic [8:0] w_act_used, w_play_bit;
  logic [3:0] w_sel_idx, w_play_idx;

  assign w_in_pick  = (r_state == ST_LEAD_PICK) || (r_state == ST_FOLLOW_PICK);
  // Leader acts in LEAD_PICK, the other player in FOLLOW_PICK.
  assign w_actor    = (r_state == ST_LEAD_PICK) ? r_leader : ~r_leader;
  assign w_act_used = w_actor ? r_p2_used : r_p1_used;
  assign w_onehot   = (io_bus.sw_sel != 9'd0) && ((io_bus.sw_sel & (io_bus.sw_sel - 9'd1)) == 9'd0);
  assign w_legal    = w_onehot && ((io_bus.sw_sel & w_act_used) == 9'd0);
  assign w_sel_idx  = onehot9_to_idx(io_bus.sw_sel);

`ifdef BAW_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0] r_tmr;
  logic [3:0]       w_low_idx;
  logic             w_any_free;

  // Lowest-index unused card of the acting player.
  always_comb begin
    w_low_idx  = '0;
    w_any_free = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      if (!w_act_used[i]) begin
        w_low_idx  = 4'(i);
        w_any_free = 1'b1;
      end
    end
  end

  // Per-pick down-counter: reloaded outside the pick states and on every
  // accepted pick; terminal count 0 marks the TIMEOUT_CYCLES-th cycle.
  always_ff @(posedge clk) begin
    if (rst || w_abort || !w_in_pick || w_play) r_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
    else if (r_tmr != '0)                       r_tmr <= r_tmr - 1'b1;
  end

  assign w_tmo      = w_in_pick && (r_tmr == '0) && w_any_free;
  assign w_play_idx = (w_confirm && w_legal) ? w_sel_idx : w_low_idx;
`else
  assign w_tmo      = 1'b0;
  assign w_play_idx = w_sel_idx;
`endif

  assign w_play     = w_in_pick && (w_tmo || (w_confirm && w_legal));
  assign w_err      = w_in_pick && w_confirm && !w_legal && !w_tmo;
  assign w_play_bit = 9'd1 << w_play_idx;

  logic       w_p1_win, w_p2_win, w_end;
  logic [3:0] w_p1_nxt, w_p2_nxt;

  assign w_p1_win = (r_res == RES_P1);
  assign w_p2_win = (r_res == RES_P2);
  assign w_p1_nxt = (w_p1_win && (r_p1_wins < 4'(WIN_TARGET))) ? r_p1_wins + 4'd1 : r_p1_wins;
  assign w_p2_nxt = (w_p2_win && (r_p2_wins < 4'(WIN_TARGET))) ? r_p2_wins + 4'd1 : r_p2_wins;
  assign w_end    = (w_p1_nxt == 4'(WIN_TARGET)) || (w_p2_nxt == 4'(WIN_TARGET)) ||
                    (r_round >= 4'(NUM_CARDS));

  // Game sequencer with registered outputs; abort and reset share one clear path.
  always_ff @(posedge clk) begin
    r_pick_err <= 1'b0;
    r_cmp_req  <= 1'b0;
    if (rst || w_abort) begin
      r_state       <= ST_IDLE;
      r_p1_card     <= '0;
      r_p2_card     <= '0;
      r_p1_used     <= '0;
      r_p2_used     <= '0;
      r_round       <= '0;
      r_p1_wins     <= '0;
      r_p2_wins     <= '0;
      r_leader      <= 1'b0;
      r_game_over   <= 1'b0;
      r_game_winner <= RES_DRAW;
      r_res         <= RES_DRAW;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state       <= ST_LEAD_PICK;
            r_p1_card     <= '0;
            r_p2_card     <= '0;
            r_p1_used     <= '0;
            r_p2_used     <= '0;
            r_round       <= 4'd1;
            r_p1_wins     <= '0;
            r_p2_wins     <= '0;
            r_leader      <= 1'b0;
            r_game_over   <= 1'b0;
            r_game_winner <= RES_DRAW;
          end
        end
        ST_LEAD_PICK, ST_FOLLOW_PICK: begin
          if (w_play) begin
            if (w_actor) begin
              r_p2_card <= w_play_idx;
              r_p2_used <= r_p2_used | w_play_bit;
            end else begin
              r_p1_card <= w_play_idx;
              r_p1_used <= r_p1_used | w_play_bit;
            end
            if (r_state == ST_LEAD_PICK) begin
              r_state <= ST_FOLLOW_PICK;
            end else begin
              r_state   <= ST_COMPARE;
              r_cmp_req <= 1'b1;
            end
          end else if (w_err) begin
            r_pick_err <= 1'b1;
          end
        end
        ST_COMPARE: begin
          r_res   <= io_bus.cmp_result;
          r_state <= ST_SCORE;
        end
        ST_SCORE: begin
          r_p1_wins <= w_p1_nxt;
          r_p2_wins <= w_p2_nxt;
          if (w_p1_win)      r_leader <= 1'b0;
          else if (w_p2_win) r_leader <= 1'b1;
          if (w_end) begin
            r_state     <= ST_DONE;
            r_game_over <= 1'b1;
            if (w_p1_nxt > w_p2_nxt)      r_game_winner <= RES_P1;
            else if (w_p2_nxt > w_p1_nxt) r_game_winner <= RES_P2;
            else                          r_game_winner <= RES_DRAW;
          end else begin
            r_round <= r_round + 4'd1;
            r_state <= ST_LEAD_PICK;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.p1_card     = r_p1_card;
  assign io_bus.p2_card     = r_p2_card;
  assign io_bus.p1_used     = r_p1_used;
  assign io_bus.p2_used     = r_p2_used;
  assign io_bus.cmp_req     = r_cmp_req;
  assign io_bus.leader      = r_leader;
  assign io_bus.round       = r_round;
  assign io_bus.p1_wins     = r_p1_wins;
  assign io_bus.p2_wins     = r_p2_wins;
  assign io_bus.game_over   = r_game_over;
  assign io_bus.game_winner = r_game_winner;
  assign io_bus.pick_err    = r_pick_err;
  assign io_bus.state_o     = r_state;

endmodule

// File: tb/tb_baw_round_controller.sv
// Self-checking bench for baw_round_controller: a reference game model
// pushes expected end-of-round results, popped when the DUT finishes SCORE.
module tb_baw_round_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  baw_round_controller_if bus ();

  baw_round_controller #(
    .NUM_CARDS     (9),
    .WIN_TARGET    (5),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  typedef struct {
    logic [3:0] p1c, p2c, p1w, p2w, rnd;
    logic [8:0] p1u, p2u;
    logic       ldr, go;
    logic [1:0] win;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cmp_cnt  = 0;
  int   err_cnt  = 0;

  // model state
  logic [3:0] m_p1c, m_p2c, m_p1w, m_p2w, m_rnd;
  logic [8:0] m_p1u, m_p2u;
  logic       m_ldr;

  always @(negedge clk) begin
    if (bus.cmp_req)  cmp_cnt <= cmp_cnt + 1;
    if (bus.pick_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic s, input logic c, input logic a);
    bus.btn_start = s; bus.btn_confirm = c; bus.btn_abort = a;
    repeat (3) @(negedge clk);
    bus.btn_start = 1'b0; bus.btn_confirm = 1'b0; bus.btn_abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pick(input int card);
    logic [8:0] sel;
    sel = 9'd1 << card;
    bus.sw_sel = sel;
    press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic start_game();
    press(1'b1, 1'b0, 1'b0);
    m_p1c = 0; m_p2c = 0; m_p1w = 0; m_p2w = 0; m_rnd = 1;
    m_p1u = 0; m_p2u = 0; m_ldr = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, bus.state_o, 0);
    chk({tag, "_p1card"}, bus.p1_card, 0);
    chk({tag, "_p2card"}, bus.p2_card, 0);
    chk({tag, "_used"}, {bus.p1_used, bus.p2_used}, 0);
    chk({tag, "_wins"}, {bus.p1_wins, bus.p2_wins}, 0);
    chk({tag, "_round"}, bus.round, 0);
    chk({tag, "_leader"}, bus.leader, 0);
    chk({tag, "_over"}, {bus.game_over, bus.game_winner, bus.cmp_req, bus.pick_err}, 0);
  endtask

  task automatic play_round(input int cl, input int cf, input logic [1:0] res);
    exp_t e;
    int   c0, guard;
    bus.cmp_result = res;
    c0 = cmp_cnt;
    pick(cl);
    pick(cf);
    // reference model
    if (m_ldr == 1'b0) begin m_p1c = 4'(cl); m_p2c = 4'(cf); end
    else               begin m_p2c = 4'(cl); m_p1c = 4'(cf); end
    m_p1u = m_p1u | (9'd1 << m_p1c);
    m_p2u = m_p2u | (9'd1 << m_p2c);
    if (res == 2'b01)      begin m_p1w++; m_ldr = 1'b0; end
    else if (res == 2'b10) begin m_p2w++; m_ldr = 1'b1; end
    e.p1c = m_p1c; e.p2c = m_p2c; e.p1u = m_p1u; e.p2u = m_p2u;
    e.p1w = m_p1w; e.p2w = m_p2w; e.ldr = m_ldr;
    if (m_p1w == 5 || m_p2w == 5 || m_rnd == 9) begin
      e.st = 3'd5; e.go = 1'b1; e.rnd = m_rnd;
      e.win = (m_p1w > m_p2w) ? 2'b01 : (m_p2w > m_p1w) ? 2'b10 : 2'b00;
    end else begin
      m_rnd++;
      e.st = 3'd1; e.go = 1'b0; e.rnd = m_rnd; e.win = 2'b00;
    end
    sb.push_back(e);
    guard = 0;
    while (bus.state_o != 3'd1 && bus.state_o != 3'd5 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("round_done_timeout", guard < 20, 1);
    e = sb.pop_front();
    chk("p1_card", bus.p1_card, e.p1c);
    chk("p2_card", bus.p2_card, e.p2c);
    chk("p1_used", bus.p1_used, e.p1u);
    chk("p2_used", bus.p2_used, e.p2u);
    chk("p1_wins", bus.p1_wins, e.p1w);
    chk("p2_wins", bus.p2_wins, e.p2w);
    chk("leader", bus.leader, e.ldr);
    chk("round", bus.round, e.rnd);
    chk("state", bus.state_o, e.st);
    chk("game_over", bus.game_over, e.go);
    chk("game_winner", bus.game_winner, e.win);
    chk("cmp_req_once", cmp_cnt - c0, 1);
  endtask

  initial begin
    bus.btn_start = 0; bus.btn_confirm = 0; bus.btn_abort = 0;
    bus.sw_sel = '0; bus.cmp_result = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

`ifdef BAW_TIMEOUT_EN
    // P1 keeps the lead through two wins, using cards 0 and 1, then idles.
    start_game();
    play_round(0, 0, 2'b01);
    play_round(1, 1, 2'b01);
    begin
      int guard;
      guard = 0;
      while (bus.state_o != 3'd2 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("tmo_fired", guard < 100, 1);
      chk("tmo_p1_card", bus.p1_card, 2);
      chk("tmo_p1_used", bus.p1_used, 9'h007);
    end
`else
    // 1: basic round
    start_game();
    chk("start_state", bus.state_o, 1);
    chk("start_round", bus.round, 1);
    play_round(4, 2, 2'b01);

    // 2: illegal confirms in FOLLOW_PICK of round 2
    begin
      int e0;
      pick(0);
      chk("follow_state", bus.state_o, 2);
      e0 = err_cnt;
      bus.sw_sel = 9'h00C;
      press(1'b0, 1'b1, 1'b0);
      bus.sw_sel = 9'h004;
      press(1'b0, 1'b1, 1'b0);
      chk("pick_err_count", err_cnt - e0, 2);
      chk("err_state", bus.state_o, 2);
      chk("err_p2_card", bus.p2_card, 2);
      chk("err_p2_used", bus.p2_used, 9'h004);
      // finish round 2 through the model: P1 lead card 0 already played
      bus.cmp_result = 2'b10;
      pick(1);
      m_p1c = 0; m_p2c = 1; m_p1u |= 9'h001; m_p2u |= 9'h002;
      m_p2w++; m_ldr = 1'b1; m_rnd++;
      chk("r2_state", bus.state_o, 1);
      chk("r2_leader", bus.leader, 1);
      chk("r2_round", bus.round, 3);
      chk("r2_p2_wins", bus.p2_wins, 1);
    end

    // 5: abort + confirm together in LEAD_PICK of round 3
    bus.sw_sel = 9'h100;
    press(1'b0, 1'b1, 1'b1);
    check_idle("abort");

    // 3: P2 wins five straight rounds
    start_game();
    for (int r = 0; r < 5; r++) play_round(r, r, 2'b10);

    // 4: nine rounds, 4/4 split and a final draw
    start_game();
    for (int r = 0; r < 9; r++)
      play_round(r, r, (r == 8) ? 2'b00 : ((r % 2 == 0) ? 2'b01 : 2'b10));

    // 6: no confirm, no timeout feature -> stays in LEAD_PICK
    start_game();
    repeat (1000) @(negedge clk);
    chk("no_tmo_state", bus.state_o, 1);

    // reset mid-game behaves like abort
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
`endif

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
